// File: rtl/mem_stream_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_pkg
// Description : Shared types and encodings for the mem_stream_port block.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_pkg;

    // Controller states; the encoding is fixed at 3 bits
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RD_REQ = 3'd2,
        RD_CAP = 3'd3,
        OUT    = 3'd4,
        FINISH = 3'd5
    } state_t;

    // Data_Memory MemWrite encodings (this block only uses NONE and WORD)
    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    // Command opcodes
    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_DUMP = 1'b1;

endpackage : mem_port_pkg
`default_nettype wire

// File: rtl/mem_stream_port_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_port_if
// Description : Command, LOAD/DUMP word streams and Data_Memory port bundle.
//               slave  = the mem_stream_port block
//               master = the environment (command source, streams, memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stream_port_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [CNT_W-1:0]  cmd_count;

    // LOAD stream (into memory)
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;

    // DUMP stream (out of memory)
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;

    // Data_Memory port
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_read;
    logic [1:0]        mem_write;
    logic [31:0]       mem_read_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_count,
        input  in_valid, in_data,
        input  out_ready,
        input  mem_read_data,
        output cmd_ready, in_ready, out_valid, out_data,
        output mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_count,
        output in_valid, in_data,
        output out_ready,
        output mem_read_data,
        input  cmd_ready, in_ready, out_valid, out_data,
        input  mem_address, mem_write_data, mem_read, mem_write
    );

endinterface : mem_stream_port_if
`default_nettype wire

// File: rtl/mem_stream_port_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_gen
// Description : Holds the word-aligned base, word count and word index of the
//               active command; produces base + 4*idx and the last-word flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    // One extra index bit so idx+1 never wraps even for the largest count
    localparam int c_IDX_W = CNT_W + 1;

    logic [ADDR_W-1:0]  r_base;
    logic [CNT_W-1:0]   r_count;
    logic [c_IDX_W-1:0] r_idx;
    logic [ADDR_W-1:0]  w_offset;

    // Latch command on start, advance the word index on every transfer
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_base  <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else if (start) begin
            r_base  <= base & ~ADDR_W'(3);
            r_count <= count;
            r_idx   <= '0;
        end else if (step) begin
            r_idx   <= r_idx + c_IDX_W'(1);
        end
    end

    // Byte offset truncated to the address width so the sum wraps naturally
    assign w_offset = ADDR_W'({r_idx, 2'b00});
    assign addr     = r_base + w_offset;
    assign last     = (r_idx + c_IDX_W'(1)) == {1'b0, r_count};

endmodule : mem_addr_gen
`default_nettype wire

// File: rtl/mem_stream_port.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_port
// Description : Hardware initiator on the Data_Memory port. LOAD writes a
//               word stream into memory, DUMP reads a region out as a word
//               stream. Holds the CPU while a command is in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stream_port
    import mem_port_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_stream_port_if.slave    bus,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done
);

    state_t             r_state;
    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_in_ready;
    logic               r_mem_read;
    logic               r_out_valid;
    logic               r_done;
    logic [31:0]        r_out_data;

    logic               w_cmd_fire;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_wr;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_last;

    assign w_cmd_fire = r_cmd_ready && bus.cmd_valid;
    assign w_in_fire  = r_in_ready && bus.in_valid;
    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_wr       = w_in_fire;

    mem_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .start  (w_cmd_fire),
        .step   (w_in_fire || w_out_fire),
        .base   (bus.cmd_base),
        .count  (bus.cmd_count),
        .addr   (w_addr),
        .last   (w_last)
    );

    // Command sequencer; every status output is a flop set on the transition
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_mem_read <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.cmd_count == '0) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else if (bus.cmd_op == OP_LOAD) begin
                            r_state    <= LOAD;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state    <= RD_REQ;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_in_fire && w_last) begin
                        r_state    <= FINISH;
                        r_in_ready <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                RD_REQ: begin
                    r_state <= RD_CAP;
                end
                RD_CAP: begin
                    // Memory returns data one cycle after the read strobe
                    r_out_data  <= bus.mem_read_data;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= RD_REQ;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Memory port: address only presented while a read or write slot is open
    assign bus.mem_address    = (r_in_ready || r_mem_read) ? w_addr : '0;
    assign bus.mem_write      = w_wr ? MW_WORD : MW_NONE;
    assign bus.mem_write_data = w_wr ? bus.in_data : 32'h0;
    assign bus.mem_read       = r_mem_read;

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

    assign cpu_hold = r_busy;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule : mem_stream_port
`default_nettype wire

// File: tb/tb_mem_stream_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stream_port
// Description : Self-checking bench for mem_stream_port with a word memory,
//               queue-based expectation model and a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stream_port;
    import mem_port_pkg::*;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst;
    logic cpu_hold, busy, done;

    always #5 clk = ~clk;

    mem_stream_port_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    mem_stream_port #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done)
    );

    // Data_Memory stand-in: 1024 words folded on address bits [11:2]
    logic [31:0] mem [0:1023];
    logic        mem_init;
    logic [31:0] rd_data;
    assign bus.mem_read_data = rd_data;

    // Registered memory: write on MemWrite=11, read data valid next cycle
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            rd_data <= '0;
        end else begin
            if (bus.mem_write == MW_WORD) mem[bus.mem_address[11:2]] <= bus.mem_write_data;
            if (bus.mem_read) rd_data <= mem[bus.mem_address[11:2]];
        end
    end

    // Expectation model
    logic [31:0] exp_mem [0:1023];
    logic [31:0] src [0:15];
    logic [31:0] exp_wr_addr[$], exp_wr_data[$], exp_rd_addr[$], exp_out[$];
    logic [31:0] wr_addr_log[$], got_out[$];
    int          wr_cyc_q[$], rd_cyc_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_wr = 0, n_rd = 0, n_acc = 0, n_done = 0, n_hold = 0;
    int last_done_cyc = 0, acc_cmd_cyc = 0, last_acc_cyc = 0;
    logic [31:0] last_rd_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_load(input logic [31:0] base, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = {base[31:2], 2'b00} + 32'(4 * i);
            exp_wr_addr.push_back(a);
            exp_wr_data.push_back(src[i]);
            exp_mem[a[11:2]] = src[i];
        end
    endtask

    task automatic model_dump(input logic [31:0] base, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = {base[31:2], 2'b00} + 32'(4 * i);
            exp_rd_addr.push_back(a);
            exp_out.push_back(exp_mem[a[11:2]]);
        end
    endtask

    // Compare process: invariants every cycle, events against model queues
    initial begin : compare
        logic        prev_valid, prev_acc, prev_done;
        logic [31:0] prev_data;
        prev_valid = 1'b0; prev_acc = 1'b0; prev_done = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            check("busy_eq_hold", 32'(busy), 32'(cpu_hold));
            check("ready_vs_hold", 32'(bus.cmd_ready), 32'(!cpu_hold));
            check("rw_exclusive", 32'(bus.mem_read && (bus.mem_write != MW_NONE)), 0);
            check("mw_encoding", 32'((bus.mem_write == MW_NONE) || (bus.mem_write == MW_WORD)), 1);
            if (bus.cmd_ready) check("idle_addr", bus.mem_address, 0);
            if (cpu_hold) n_hold++;
            if (bus.cmd_valid && bus.cmd_ready) acc_cmd_cyc = cyc;

            if (bus.mem_write == MW_WORD) begin
                n_wr++;
                wr_cyc_q.push_back(cyc);
                wr_addr_log.push_back(bus.mem_address);
                check("in_ready_on_write", 32'(bus.in_ready), 1);
                check("wr_expected", 32'(exp_wr_addr.size() != 0), 1);
                if (exp_wr_addr.size() != 0) begin
                    check("wr_addr", bus.mem_address, exp_wr_addr.pop_front());
                    check("wr_data", bus.mem_write_data, exp_wr_data.pop_front());
                end
            end

            if (bus.mem_read) begin
                n_rd++;
                rd_cyc_q.push_back(cyc);
                last_rd_addr = bus.mem_address;
                check("rd_while_pending", 32'(bus.out_valid), 0);
                check("rd_expected", 32'(exp_rd_addr.size() != 0), 1);
                if (exp_rd_addr.size() != 0) check("rd_addr", bus.mem_address, exp_rd_addr.pop_front());
            end

            if (bus.out_valid && !prev_valid) begin
                check("valid_has_read", 32'(rd_cyc_q.size() != 0), 1);
                if (rd_cyc_q.size() != 0) check("rd_to_valid", 32'(cyc - rd_cyc_q.pop_front()), 2);
            end

            if (prev_valid && !prev_acc) begin
                check("out_valid_held", 32'(bus.out_valid), 1);
                check("out_data_held", bus.out_data, prev_data);
            end

            if (bus.out_valid && bus.out_ready) begin
                n_acc++;
                last_acc_cyc = cyc;
                got_out.push_back(bus.out_data);
                check("out_expected", 32'(exp_out.size() != 0), 1);
                if (exp_out.size() != 0) check("out_data", bus.out_data, exp_out.pop_front());
            end

            if (done) begin
                n_done++;
                last_done_cyc = cyc;
                check("done_one_cycle", 32'(prev_done), 0);
            end

            prev_valid = bus.out_valid;
            prev_acc   = bus.out_valid && bus.out_ready;
            prev_data  = bus.out_data;
            prev_done  = done;
        end
    end

    // Issue one command; called half-way through a cycle with the DUT idle
    task automatic issue(input logic op, input logic [31:0] base, input logic [15:0] count);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_count = count;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = src[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // mode 0: out_ready tied high; mode 1: high one cycle in three
    task automatic wait_done(input int mode, input int budget, input logic junk_in);
        int start;
        int k;
        start = n_done;
        k = 0;
        while (n_done == start && k < budget) begin
            bus.out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            bus.in_valid  = junk_in;
            bus.in_data   = 32'hBAD0_BAD0;
            @(posedge clk); #1;
            k++;
        end
        check("done_within_budget", 32'(n_done != start), 1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int s_done, s_wr, s_rd, s_hold;
        rst = 1'b0;
        mem_init = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_base = '0; bus.cmd_count = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = 32'hC0DE_0000 | 32'(i);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        mem_init = 1'b0;

        // Reset state
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_cpu_hold", 32'(cpu_hold), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_read", 32'(bus.mem_read), 0);
        check("rst_mem_write", 32'(bus.mem_write), 0);
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_data", bus.out_data, 0);

        // Reset in the middle of a LOAD: only the first four words land
        for (int i = 0; i < 10; i++) src[i] = 32'h100 + 32'(i);
        model_load(32'h10F0, 4);
        s_done = n_done;
        issue(OP_LOAD, 32'h10F0, 16'd10);
        stream(4);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort_cmd_ready", 32'(bus.cmd_ready), 1);
        check("abort_cpu_hold", 32'(cpu_hold), 0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_wr_count", 32'(n_wr), 4);
        check("abort_no_done", 32'(n_done - s_done), 0);
        check("abort_wr_q_empty", 32'(exp_wr_addr.size()), 0);
        check("abort_mem_10f0", mem[10'h03C], 32'h0000_0100);
        check("abort_mem_10fc", mem[10'h03F], 32'h0000_0103);
        check("abort_mem_1100", mem[10'h040], 32'hC0DE_0040);
        check("abort_mem_1114", mem[10'h045], 32'hC0DE_0045);

        // LOAD 9..0 at 0x10F0, continuous stream
        for (int i = 0; i < 10; i++) src[i] = 32'(9 - i);
        model_load(32'h10F0, 10);
        wr_cyc_q.delete();
        s_hold = n_hold;
        issue(OP_LOAD, 32'h10F0, 16'd10);
        stream(10);
        wait_done(0, 50, 1'b0);
        check("load_writes", 32'(wr_cyc_q.size()), 10);
        check("load_consecutive", 32'(wr_cyc_q[9] - wr_cyc_q[0]), 9);
        check("load_done_after_last", 32'(last_done_cyc - wr_cyc_q[9]), 1);
        check("load_duration", 32'(last_done_cyc - acc_cmd_cyc), 11);
        check("load_hold_cycles", 32'(n_hold - s_hold), 11);
        check("load_wr_q_empty", 32'(exp_wr_addr.size()), 0);
        check("load_mem_10f0", mem[10'h03C], 32'd9);
        check("load_mem_1114", mem[10'h045], 32'd0);

        // DUMP 10 words with out_ready high
        got_out.delete();
        s_rd = n_rd;
        model_dump(32'h10F0, 10);
        issue(OP_DUMP, 32'h10F0, 16'd10);
        wait_done(0, 100, 1'b1);
        check("dump_count", 32'(got_out.size()), 10);
        check("dump_first", got_out[0], 32'd9);
        check("dump_last", got_out[9], 32'd0);
        check("dump_reads", 32'(n_rd - s_rd), 10);
        check("dump_done_after_acc", 32'(last_done_cyc - last_acc_cyc), 1);
        check("dump_duration", 32'(last_done_cyc - acc_cmd_cyc), 31);
        check("dump_out_q_empty", 32'(exp_out.size()), 0);

        // DUMP with out_ready high one cycle in three
        got_out.delete();
        s_rd = n_rd;
        model_dump(32'h10F0, 10);
        issue(OP_DUMP, 32'h10F0, 16'd10);
        wait_done(1, 200, 1'b0);
        check("stall_count", 32'(got_out.size()), 10);
        check("stall_reads", 32'(n_rd - s_rd), 10);
        check("stall_out_q_empty", 32'(exp_out.size()), 0);
        check("stall_fifth", got_out[4], 32'd5);

        // Zero-length command
        s_wr = n_wr;
        s_rd = n_rd;
        issue(OP_LOAD, 32'h2000, 16'd0);
        wait_done(0, 10, 1'b0);
        check("zero_done_latency", 32'(last_done_cyc - acc_cmd_cyc), 1);
        check("zero_no_write", 32'(n_wr - s_wr), 0);
        check("zero_no_read", 32'(n_rd - s_rd), 0);

        // Unaligned base is forced to a word boundary
        got_out.delete();
        model_dump(32'h10F3, 1);
        issue(OP_DUMP, 32'h10F3, 16'd1);
        wait_done(0, 20, 1'b0);
        check("unaligned_rd_addr", last_rd_addr, 32'h0000_10F0);
        check("unaligned_data", got_out[0], 32'd9);

        // Address wrap, with a command pulse while busy that must be ignored
        src[0] = 32'hAAAA_5555;
        src[1] = 32'h1234_5678;
        model_load(32'hFFFF_FFFC, 2);
        wr_addr_log.delete();
        s_rd = n_rd;
        s_done = n_done;
        issue(OP_LOAD, 32'hFFFF_FFFC, 16'd2);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_DUMP;
        bus.cmd_base  = 32'h10F0;
        bus.cmd_count = 16'd5;
        stream(2);
        bus.cmd_valid = 1'b0;
        wait_done(0, 20, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("wrap_addr0", wr_addr_log[0], 32'hFFFF_FFFC);
        check("wrap_addr1", wr_addr_log[1], 32'h0000_0000);
        check("wrap_mem_top", mem[10'h3FF], 32'hAAAA_5555);
        check("wrap_mem_zero", mem[10'h000], 32'h1234_5678);
        check("busy_cmd_ignored_rd", 32'(n_rd - s_rd), 0);
        check("busy_cmd_ignored_done", 32'(n_done - s_done), 1);
        check("final_cmd_ready", 32'(bus.cmd_ready), 1);
        check("final_queues_empty",
              32'(exp_wr_addr.size() + exp_rd_addr.size() + exp_out.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_stream_port
`default_nettype wire
